fifo_destino: RTL and testbench

//  Destination FIFO downstream of the VC arbiter/router; one instance each on D0 and D1.

---
 rtl/fifo_destino_pkg.sv | 19 +
 rtl/fifo_destino_memoria_dual.sv | 30 +++
 rtl/fifo_destino.sv | 84 ++++++++
 tb/tb_fifo_destino.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fifo_destino_pkg.sv
// Shared constants and types for the destination FIFO placed after the VC arbiter.
// Datapath width, default geometry and the pause/almost-empty thresholds live here.
package fifo_destino_pkg;

  localparam int DEF_DATA_WIDTH  = 6;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_ADDR_WIDTH  = 3;
  localparam int DEF_UMBRAL_ALTO = 6;
  localparam int DEF_UMBRAL_BAJO = 1;

  // Accepted operations in one cycle, encoded as {push_ok, pop_ok}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_t;

endpackage

// File: rtl/fifo_destino_memoria_dual.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// registered read port; array contents are never reset, only the read register is.
module memoria_dual #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-address write and read return the old word (full FIFO push+pop case)
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_destino.sv
// Destination FIFO: pointer/count control, threshold flags and sticky error.
// Flags decode the count register only; storage sits in memoria_dual.
module fifo_destino
  import fifo_destino_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int UMBRAL_ALTO = DEF_UMBRAL_ALTO,
  parameter int UMBRAL_BAJO = DEF_UMBRAL_BAJO
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  pause,
  output logic                  almost_empty,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ALTO = (ADDR_WIDTH+1)'(UMBRAL_ALTO);
  localparam logic [ADDR_WIDTH:0] CNT_BAJO = (ADDR_WIDTH+1)'(UMBRAL_BAJO);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  bad_op;
  op_t                   op;

  assign empty        = (count == '0);
  assign full         = (count == CNT_FULL);
  assign pause        = (count >= CNT_ALTO);
  assign almost_empty = (count <= CNT_BAJO);

  // A pop on a full FIFO frees the slot the concurrent push lands in
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);
  assign bad_op  = (push && full && !pop) || (pop && empty);
  assign op      = op_t'({push_ok, pop_ok});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      valid_out <= pop_ok;
      if (bad_op) error <= 1'b1;
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  memoria_dual #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_memoria (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_destino.sv
// Scoreboard bench for fifo_destino: a queue-based reference model predicts
// popped words and flag levels; a negedge monitor compares every cycle.
module tb_fifo_destino;

  localparam int DEPTH = 8;
  localparam int HI    = 6;
  localparam int LO    = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [5:0] data_in = '0;
  logic [5:0] data_out;
  logic       valid_out, empty, full, pause, almost_empty, error;

  int checks = 0;
  int errors = 0;

  logic [5:0] model_q[$];
  logic [5:0] exp_q[$];
  bit         model_err = 1'b0;
  bit         exp_valid = 1'b0;

  fifo_destino dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .empty        (empty),
    .full         (full),
    .pause        (pause),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model applies the same request at the edge.
  task automatic step(input bit p, input bit q, input logic [5:0] d);
    int sz;
    push = p;
    pop = q;
    data_in = d;
    @(posedge clk);
    sz = model_q.size();
    exp_valid = q && (sz > 0);
    if (q && sz == 0) model_err = 1'b1;
    if (p && sz == DEPTH && !q) model_err = 1'b1;
    if (exp_valid) exp_q.push_back(model_q.pop_front());
    if (p && (sz < DEPTH || q)) model_q.push_back(d);
    #1;
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic do_reset(input bit hold_push);
    #2;
    reset = 1'b1;
    push = hold_push;
    data_in = 6'h2A;
    #1;
    check("async_empty", empty, 1);
    model_q.delete();
    exp_q.delete();
    model_err = 1'b0;
    exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push = 1'b0;
  endtask

  task automatic fill(input int n, input logic [5:0] base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 6'(base + i));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 6'h00);
  endtask

  // Monitor: flags against model occupancy, data against the scoreboard queue
  initial begin
    logic [5:0] last;
    logic [5:0] e;
    int         sz;
    last = '0;
    forever begin
      @(negedge clk);
      if (reset) last = '0;
      sz = model_q.size();
      check("empty", empty, (sz == 0));
      check("full", full, (sz == DEPTH));
      check("pause", pause, (sz >= HI));
      check("almost_empty", almost_empty, (sz <= LO));
      check("error", error, model_err);
      check("valid_out", valid_out, exp_valid);
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("data_out_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("data_out", data_out, e);
          last = e;
        end
      end else begin
        check("data_out_hold", data_out, last);
      end
    end
  end

  initial begin
    // Reset held with push asserted: nothing may be written
    push = 1'b1;
    data_in = 6'h3F;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push = 1'b0;
    step(1'b0, 1'b0, 6'h00);
    check("reset_data_out", data_out, 0);

    // Fill 0x01..0x08, then drain
    fill(8, 6'h01);
    drain(8);

    // Overflow on full FIFO
    fill(8, 6'h11);
    step(1'b1, 1'b0, 6'h3F);
    drain(8);

    // Push and pop together on full FIFO
    do_reset(1'b0);
    fill(8, 6'h21);
    step(1'b1, 1'b1, 6'h2A);
    drain(8);

    // Underflow, then push+pop on empty
    step(1'b0, 1'b1, 6'h00);
    do_reset(1'b0);
    step(1'b1, 1'b1, 6'h15);
    step(1'b0, 1'b1, 6'h00);

    // Interleaved traffic so pointers wrap, then reset at count 5
    do_reset(1'b0);
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), 6'($urandom));
    while (model_q.size() < 5) step(1'b1, 1'b0, 6'($urandom));
    while (model_q.size() > 5) step(1'b0, 1'b1, 6'h00);
    do_reset(1'b1);
    step(1'b0, 1'b1, 6'h00);
    fill(3, 6'h30);
    drain(3);

    // Long random run with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1) == 1);
      else step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 6'($urandom));
    end
    drain(DEPTH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
